// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: FSM state encoding, default reset PC and the
// IF/ID pipeline register layout consumed by the decode stage.
package fetch_stage_pkg;

    localparam int unsigned PKG_XLEN     = 32;
    localparam logic [31:0] PKG_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        S_REQ,
        S_WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] pc4;
        logic [31:0]         instr;
    } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and hands {pc, pc+4, instr} to decode via a 1-entry buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = PKG_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = PKG_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [31:0]     id_instr
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            drop;
    logic            out_valid;
    if_id_t          out_q;
    logic            buf_free;
    logic            req_fire;

    // A request is only issued when its response is guaranteed a free slot.
    assign buf_free       = !out_valid || id_ready;
    assign imem_req_valid = !rst && (state == S_REQ) && buf_free && !redirect_valid;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign id_valid = out_valid;
    assign id_pc    = out_q.pc;
    assign id_pc4   = out_q.pc4;
    assign id_instr = out_q.instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC & ALIGN_MASK;
            inflight_pc <= '0;
            drop        <= 1'b0;
            out_valid   <= 1'b0;
            out_q       <= '0;
        end else if (redirect_valid) begin
            // Redirect flushes the buffer; an in-flight fetch is marked stale.
            pc        <= redirect_pc & ALIGN_MASK;
            out_valid <= 1'b0;
            if (state == S_WAIT) begin
                if (imem_rsp_valid) begin
                    state <= S_REQ;
                    drop  <= 1'b0;
                end else begin
                    drop <= 1'b1;
                end
            end else if (req_fire) begin
                inflight_pc <= pc;
                state       <= S_WAIT;
                drop        <= 1'b1;
            end
        end else begin
            if (out_valid && id_ready) begin
                out_valid <= 1'b0;
            end
            if (state == S_REQ) begin
                if (req_fire) begin
                    inflight_pc <= pc;
                    state       <= S_WAIT;
                end
            end else if (imem_rsp_valid) begin
                state <= S_REQ;
                if (drop) begin
                    drop <= 1'b0;
                end else begin
                    out_q.pc    <= inflight_pc;
                    out_q.pc4   <= inflight_pc + XLEN'(4);
                    out_q.instr <= imem_rsp_data;
                    out_valid   <= 1'b1;
                    pc          <= inflight_pc + XLEN'(4);
                end
            end
        end
    end

endmodule
